// File: rtl/message_validator.sv
// Reader of the 32-byte decrypted-message RAM: confirms every byte is 'a'..'z' or space
// and reports pass/fail plus the index of the first offending byte.
module message_validator #(
  parameter int         MESSAGE_LENGTH = 32,
  parameter int         ADDR_WIDTH     = 5,
  parameter logic [7:0] CHAR_LO        = 8'h61,
  parameter logic [7:0] CHAR_HI        = 8'h7A,
  parameter logic [7:0] CHAR_SPACE     = 8'h20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  done_ack,
  output logic [ADDR_WIDTH-1:0] d_mem_addr,
  input  logic [7:0]            d_mem_data_read,
  output logic                  done,
  output logic                  valid,
  output logic [ADDR_WIDTH-1:0] fail_index
);

  // Handshake: start is sampled only in IDLE and begins a pass; done stays high
  // for the whole of DONE and is released only by done_ack sampled in DONE.
  // start seen outside IDLE and done_ack seen outside DONE have no effect.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SET_ADDR  = 3'd1,
    WAIT_READ = 3'd2,
    CHECK     = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_K = ADDR_WIDTH'(MESSAGE_LENGTH - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] k;
  logic                  byte_ok;

  assign byte_ok = ((d_mem_data_read >= CHAR_LO) && (d_mem_data_read <= CHAR_HI)) ||
                   (d_mem_data_read == CHAR_SPACE);

  always_comb begin
    d_mem_addr = '0;
    if ((state == SET_ADDR) || (state == WAIT_READ) || (state == CHECK))
      d_mem_addr = k;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      k          <= '0;
      done       <= 1'b0;
      valid      <= 1'b0;
      fail_index <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            k          <= '0;
            valid      <= 1'b0;
            fail_index <= '0;
            state      <= SET_ADDR;
          end
        end
        SET_ADDR:  state <= WAIT_READ;
        WAIT_READ: state <= CHECK;
        CHECK: begin
          // Read data lags the address by two clocks, so the byte for k is
          // on the bus exactly while in CHECK.
          if (!byte_ok) begin
            fail_index <= k;
            valid      <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end else if (k == LAST_K) begin
            valid <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            k     <= k + ADDR_WIDTH'(1);
            state <= SET_ADDR;
          end
        end
        DONE: begin
          if (done_ack) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_message_validator.sv
// Directed bench for message_validator with a 2-clock-latency RAM model.
module tb_message_validator;

  localparam int ML = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          done_ack;
  logic [AW-1:0] d_mem_addr;
  logic [7:0]    d_mem_data_read;
  logic          done;
  logic          valid;
  logic [AW-1:0] fail_index;

  int n_assert = 0;
  int n_fail   = 0;

  message_validator dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .done_ack(done_ack),
    .d_mem_addr(d_mem_addr),
    .d_mem_data_read(d_mem_data_read),
    .done(done),
    .valid(valid),
    .fail_index(fail_index)
  );

  always #5 clk = ~clk;

  // RAM model: data appears two clocks after the address
  logic [7:0] mem [ML];
  logic [7:0] rd1, rd2;
  always @(posedge clk) begin
    rd1 <= mem[d_mem_addr];
    rd2 <= rd1;
  end
  assign d_mem_data_read = rd2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_a();
    for (int i = 0; i < ML; i++) mem[i] = 8'h61;
  endtask

  // Starts a pass, checks the address walk, and reports the edge on which done rose.
  task automatic run_pass(input int exp_edge, input int pulse_at, output int max_addr);
    int done_edge;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("start_valid_clr", 32'(valid), 32'd0);
    chk("start_addr0", 32'(d_mem_addr), 32'd0);
    chk("start_done0", 32'(done), 32'd0);
    done_edge = -1;
    max_addr  = 0;
    for (int e = 1; e <= 120 && done_edge < 0; e++) begin
      if (e == pulse_at) begin
        @(negedge clk);
        start = 1'b1;
      end
      @(posedge clk);
      #1 start = 1'b0;
      if (done) done_edge = e;
      else if (int'(d_mem_addr) > max_addr) max_addr = int'(d_mem_addr);
      if (e < exp_edge) chk("addr_walk", 32'(d_mem_addr), 32'(e / 3));
    end
    chk("done_edge", 32'(done_edge), 32'(exp_edge));
  endtask

  task automatic ack();
    @(negedge clk);
    done_ack = 1'b1;
    @(posedge clk);
    #1 done_ack = 1'b0;
    chk("ack_done_low", 32'(done), 32'd0);
  endtask

  initial begin
    int    max_addr;
    string msg;
    logic [7:0] bvals [7];
    logic       bexp  [7];
    bvals = '{8'h60, 8'h7B, 8'h1F, 8'hFF, 8'h20, 8'h61, 8'h7A};
    bexp  = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1};

    // Reset
    reset = 1'b1; start = 1'b0; done_ack = 1'b0;
    fill_a();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_fail_index", 32'(fail_index), 32'd0);
    chk("rst_addr", 32'(d_mem_addr), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // 1: "attack at dawn" padded with spaces
    msg = "attack at dawn";
    for (int i = 0; i < ML; i++) mem[i] = (i < msg.len()) ? msg[i] : 8'h20;
    run_pass(96, 0, max_addr);
    chk("t1_valid", 32'(valid), 32'd1);
    chk("t1_fail_index", 32'(fail_index), 32'd0);
    chk("t1_max_addr", 32'(max_addr), 32'd31);
    ack();

    // 2: uppercase at byte 5 aborts early
    fill_a();
    mem[5] = 8'h41;
    run_pass(18, 0, max_addr);
    chk("t2_valid", 32'(valid), 32'd0);
    chk("t2_fail_index", 32'(fail_index), 32'd5);
    chk("t2_max_addr", 32'(max_addr), 32'd5);
    ack();

    // 3: boundary values at byte 31
    for (int b = 0; b < 7; b++) begin
      fill_a();
      mem[31] = bvals[b];
      run_pass(96, 0, max_addr);
      chk("t3_valid", 32'(valid), 32'(bexp[b]));
      chk("t3_fail_index", 32'(fail_index), bexp[b] ? 32'd0 : 32'd31);
      if (b < 6) ack();
    end

    // 4: handshake (last boundary run passed, so valid=1)
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("t4_hold_done", 32'(done), 32'd1);
      chk("t4_hold_valid", 32'(valid), 32'd1);
      chk("t4_hold_fail_index", 32'(fail_index), 32'd0);
    end
    @(negedge clk);
    start = 1'b1; done_ack = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; done_ack = 1'b0;
    chk("t4_ack_done", 32'(done), 32'd0);
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("t4_idle_done", 32'(done), 32'd0);
      chk("t4_idle_valid_kept", 32'(valid), 32'd1);
      chk("t4_idle_addr", 32'(d_mem_addr), 32'd0);
    end
    run_pass(96, 0, max_addr);
    chk("t4_valid", 32'(valid), 32'd1);
    ack();

    // 5: start re-pulsed mid-pass is ignored
    fill_a();
    run_pass(96, 40, max_addr);
    chk("t5_valid", 32'(valid), 32'd1);
    ack();

    // 6: reset mid-pass
    fill_a();
    mem[20] = 8'h7B;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (50) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_valid", 32'(valid), 32'd0);
    chk("t6_fail_index", 32'(fail_index), 32'd0);
    chk("t6_addr", 32'(d_mem_addr), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    fill_a();
    run_pass(96, 0, max_addr);
    chk("t6_after_valid", 32'(valid), 32'd1);
    chk("t6_after_fail_index", 32'(fail_index), 32'd0);
    ack();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/message_validator.md
Name: message_validator

Overview:
- Reads the 32-byte decrypted-message RAM after the RC4 decryption block has filled it.
- Checks that every byte is a lowercase ASCII letter or a space.
- Reports pass/fail and the index of the first bad byte to the key-search controller.
- Is the reader end of the decrypted-memory interface; uses the same start/done/done_ack handshake as the decryption block.

Parameters:
- MESSAGE_LENGTH, 32: number of bytes checked (addresses 0..MESSAGE_LENGTH-1).
- ADDR_WIDTH, 5: width of the D-memory address; must satisfy 2**ADDR_WIDTH >= MESSAGE_LENGTH.
- CHAR_LO, 8'h61: lowest accepted letter ('a').
- CHAR_HI, 8'h7A: highest accepted letter ('z').
- CHAR_SPACE, 8'h20: the only accepted non-letter (space).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a validation pass; sampled only in IDLE.
- done_ack  in  1  controller acknowledges done; sampled only in DONE.
- d_mem_addr  out  ADDR_WIDTH  read address into decrypted-message RAM.
- d_mem_data_read  in  8  RAM read data; valid 2 clocks after the address is presented.
- done  out  1  high for the whole time the FSM is in DONE.
- valid  out  1  1 = every byte accepted; meaningful while done=1.
- fail_index  out  ADDR_WIDTH  index of the first rejected byte; meaningful when done=1 and valid=0.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, k=0, done=0, valid=0, fail_index=0, d_mem_addr=0.
- FSM states: IDLE, SET_ADDR, WAIT_READ, CHECK, DONE.
- IDLE:
  - start=1: k<=0, valid<=0, fail_index<=0, go to SET_ADDR.
  - Otherwise stay in IDLE.
- SET_ADDR -> WAIT_READ -> CHECK, unconditionally, one clock each.
- d_mem_addr:
  - Equals k in SET_ADDR, WAIT_READ and CHECK.
  - 0 in all other states.
  - Combinational from state and k.
- CHECK: the byte is accepted iff (CHAR_LO <= byte <= CHAR_HI) or byte == CHAR_SPACE. All comparisons unsigned 8-bit. Then:
  - Byte rejected: fail_index<=k, valid<=0, go to DONE. Early abort; remaining bytes are not read.
  - Byte accepted and k==MESSAGE_LENGTH-1: valid<=1, go to DONE.
  - Byte accepted otherwise: k<=k+1, go to SET_ADDR.
- Throughput: 3 clocks per byte.
- Latency, counted from the edge that samples start:
  - All bytes accepted: DONE entered on edge 3*MESSAGE_LENGTH (96 by default).
  - First rejection at index n: DONE entered on edge 3*(n+1).
- DONE:
  - done=1; valid and fail_index held stable.
  - done_ack=1: go to IDLE.
  - start in DONE is ignored, including when asserted in the same cycle as done_ack.
- In IDLE, valid and fail_index keep the last result until the next accepted start.
- Inputs outside their sampling states are ignored with no side effects: start while busy, done_ack outside DONE.
- k never wraps: it stops at MESSAGE_LENGTH-1.
- Any unreachable state encoding recovers to IDLE on the next clock.
- Reset asserted mid-pass aborts immediately to the reset values. No partial result is kept.
- Block is read-only: no write enable toward D-memory. The RAM must not be written during a pass; this is guaranteed by the controller sequencing.

Test Plan:
1. RAM holds "attack at dawn" padded with spaces to 32 bytes; pulse start -> d_mem_addr walks 0..31, one address per 3 clocks; done=1 at edge 96; valid=1; fail_index=0.
2. Byte 5 = 8'h41 ('A'), all others 'a'; start -> done=1 at edge 18; valid=0; fail_index=5; addresses above 5 are never presented.
3. Boundary values, one corrupted byte per run (otherwise all-'a'), byte 31 set to the value under test:
   - 8'h20, 8'h61, 8'h7A -> valid=1.
   - 8'h60, 8'h7B, 8'h1F, 8'hFF -> valid=0, fail_index=31, done at edge 96.
4. Handshake:
   - Hold done_ack=0 for 10 clocks in DONE -> done stays 1 and outputs stay stable.
   - Assert start and done_ack together -> FSM goes to IDLE, no new pass starts.
   - Next start -> valid clears to 0 on that edge.
5. start re-pulsed at edge 40 of a passing run -> ignored; completion still at edge 96 with valid=1.
6. Assert reset at edge 50 of a run -> done=0, valid=0, fail_index=0, d_mem_addr=0 asynchronously. After reset release, a new start gives a correct full result.
